// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier.
// The multiplier's optional signed mode is enabled by defining MULT_SIGNED_EN.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold the value n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/register.sv
// Generic enabled register with asynchronous active-high reset.
module register #(
    parameter int size = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [size-1:0] regIn,
    output logic [size-1:0] regOut
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regOut <= '0;
        end else if (enable) begin
            regOut <= regIn;
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Multicycle shift-add multiplier producing a 2*size-bit product.
// Define MULT_SIGNED_EN for two's complement operands and product.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int size = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [size-1:0]   opA,
    input  logic [size-1:0]   opB,
    output logic              busy,
    output logic              done,
    output logic [2*size-1:0] product
);

    localparam int CW = cnt_width(size);

    state_t              state_q, state_d;
    logic                load_en;
    logic [size-1:0]     mcand_q;
    logic [2*size-1:0]   acc_q;
    logic                carry_q;
    logic [CW-1:0]       cnt_q;
    logic [size:0]       sum_w;
    logic [2*size:0]     shift_w;
    logic [2*size-1:0]   product_d;
    logic [size-1:0]     op_a_w;
    logic [size-1:0]     op_b_w;

`ifdef MULT_SIGNED_EN
    logic sign_q;

    // Magnitudes fit in size bits unsigned, including the most negative value.
    assign op_a_w = opA[size-1] ? (~opA + size'(1)) : opA;
    assign op_b_w = opB[size-1] ? (~opB + size'(1)) : opB;
`else
    assign op_a_w = opA;
    assign op_b_w = opB;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    load_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_comb begin
        sum_w = {carry_q, acc_q[2*size-1:size]};
        if (acc_q[0]) begin
            sum_w = {1'b0, acc_q[2*size-1:size]} + {1'b0, mcand_q};
        end
        shift_w = {sum_w, acc_q[size-1:0]} >> 1;
`ifdef MULT_SIGNED_EN
        product_d = sign_q ? (~shift_w[2*size-1:0] + (2*size)'(1)) : shift_w[2*size-1:0];
`else
        product_d = shift_w[2*size-1:0];
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef MULT_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q <= op_a_w;
                        acc_q   <= {{size{1'b0}}, op_b_w};
                        carry_q <= 1'b0;
                        cnt_q   <= CW'(size);
`ifdef MULT_SIGNED_EN
                        sign_q  <= opA[size-1] ^ opB[size-1];
`endif
                    end
                end
                CALC: begin
                    {carry_q, acc_q} <= shift_w;
                    cnt_q            <= cnt_q - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    register #(
        .size(2*size)
    ) u_product_reg (
        .clock  (clock),
        .reset  (reset),
        .enable (load_en),
        .regIn  (product_d),
        .regOut (product)
    );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (size=8); honours MULT_SIGNED_EN.
module tb_shift_add_multiplier;

    localparam int SIZE = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [SIZE-1:0]   op_a;
    logic [SIZE-1:0]   op_b;
    logic              busy;
    logic              done;
    logic [2*SIZE-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    shift_add_multiplier #(
        .size(SIZE)
    ) dut (
        .clock   (clk),
        .reset   (rst),
        .start   (start),
        .opA     (op_a),
        .opB     (op_b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request yields its product size edges later,
    // shown for one cycle; the block is busy for size+1 edges after acceptance.
    bit                m_busy = 1'b0;
    bit                m_done = 1'b0;
    logic [2*SIZE-1:0] m_prod = '0;
    logic [2*SIZE-1:0] m_res  = '0;
    int                m_age  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_prod = '0;
            m_age  = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_age  = 0;
`ifdef MULT_SIGNED_EN
                m_res  = 16'(int'($signed(op_a)) * int'($signed(op_b)));
`else
                m_res  = 16'(int'(op_a) * int'(op_b));
`endif
            end
        end else begin
            m_age++;
            if (m_age == SIZE) begin
                m_done = 1'b1;
                m_prod = m_res;
            end else if (m_age == SIZE + 1) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("busy_model", 32'(busy), 32'(m_busy));
        check("done_model", 32'(done), 32'(m_done));
        check("product_model", 32'(product), 32'(m_prod));
    end

    // Launch one operation from IDLE, scramble operands after acceptance, and
    // check latency (accepting edge counted as edge 1) and the product.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string nm);
        int edges;
        bit seen;
        @(posedge clk);
        #2;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        edges = 1;
        #2;
        start = 1'b0;
        op_a  = 8'hA5;
        op_b  = 8'h5A;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                edges++;
            end
        end
        check({nm, "_done_seen"}, 32'(seen), 32'(1));
        check({nm, "_latency"}, 32'(edges), 32'(9));
        check({nm, "_product"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int   last;
        int   pulses;
        int   dones;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #110;
        rst = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_product", 32'(product), 32'(0));

`ifdef MULT_SIGNED_EN
        do_op(8'hFD, 8'd5, 16'hFFF1, "s_m3x5");
        do_op(8'h80, 8'h80, 16'd16384, "s_m128xm128");
        do_op(8'hFF, 8'd1, 16'hFFFF, "s_m1x1");
        do_op(8'd13, 8'd11, 16'd143, "s_13x11");
`else
        do_op(8'd13, 8'd11, 16'd143, "13x11");
        do_op(8'd255, 8'd255, 16'hFE01, "255x255");
        do_op(8'd0, 8'd200, 16'd0, "0x200");
        do_op(8'd1, 8'd255, 16'd255, "1x255");
`endif

        // start pulsed mid-calculation must be ignored
        @(posedge clk);
        #2;
        start = 1'b1;
        op_a  = 8'd20;
        op_b  = 8'd10;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1;
        op_a  = 8'd9;
        op_b  = 8'd9;
        @(posedge clk);
        #2;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                check("ignore_product", 32'(product), 32'(200));
            end
        end
        check("ignore_done_count", 32'(dones), 32'(1));

        // reset 4 edges into CALC aborts without a done
        @(posedge clk);
        #2;
        start = 1'b1;
        op_a  = 8'd100;
        op_b  = 8'd2;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_product", 32'(product), 32'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'(0));
        do_op(8'd7, 8'd6, 16'd42, "7x6");

        // start held high: back-to-back operations every size+2 cycles
        @(posedge clk);
        #2;
        start  = 1'b1;
        op_a   = 8'd3;
        op_b   = 8'd5;
        last   = -1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                check("held_product", 32'(product), 32'(15));
                if (last >= 0) check("held_spacing", 32'(i - last), 32'(10));
                last = i;
                pulses++;
            end
        end
        start = 1'b0;
        check("held_pulses", 32'(pulses), 32'(4));
        repeat (12) @(posedge clk);
        check("final_idle", 32'(busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
